// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions: sequencer state encoding, NOP word, register-zero index.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2
    } hz_state_t;

    // Instruction word IF/ID loads when flushed.
    localparam logic [31:0] NOP_INSTR = 32'hFC000000;

    // Writes to register zero never create a dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Load in ID/EX whose destination is read by the instruction in IF/ID.
    function automatic logic load_use_hazard(
        input logic       memread,
        input logic [4:0] ex_rt,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt,
        input logic       id_uses_rt
    );
        return memread && (ex_rt != REG_ZERO) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
// Latency: count visible one cycle after the increment/clear request.
// Backpressure: none; holds at all-ones instead of wrapping.
module pipe_hazard_ctrl_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    // Clear first, then increment unless already saturated.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, redirect and data-memory waits.
// Latency: control outputs are combinational from state and inputs; counters lag one cycle.
// Backpressure: freezes PC/IF/ID/MEM while memory is busy; aborts after MEM_TIMEOUT wait cycles.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int TO_W        = 8,
    parameter int MEM_TIMEOUT = 200
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       ifid_rs_i,
    input  logic [4:0]       ifid_rt_i,
    input  logic             ifid_uses_rt_i,
    input  logic             idex_memread_i,
    input  logic [4:0]       idex_rt_i,
    input  logic             branch_taken_i,
    input  logic             jump_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ack_i,
    input  logic             cnt_clr_i,
    output logic             pc_we_o,
    output logic             ifid_we_o,
    output logic             ifid_flush_o,
    output logic             idex_flush_o,
    output logic             mem_hold_o,
    output logic             mem_abort_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

    hz_state_t       state_q, state_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            err_q;
    logic            err_set;
    logic            lu;
    logic            redirect;
    logic            redirect_fire;
    logic            stall_inc;

    // Hazard terms shared by RUN and the ack cycle of MEM_WAIT; a stall masks a redirect
    // because ID re-evaluates the branch on the next cycle.
    always_comb begin
        lu       = load_use_hazard(idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i, ifid_uses_rt_i);
        redirect = (branch_taken_i || jump_i) && !lu;
    end

    // Next-state and control outputs; reset forces NOPs into IF/ID and ID/EX.
    always_comb begin
        state_d       = state_q;
        to_d          = to_q;
        err_set       = 1'b0;
        pc_we_o       = 1'b0;
        ifid_we_o     = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_flush_o  = 1'b0;
        mem_hold_o    = 1'b0;
        mem_abort_o   = 1'b0;
        redirect_fire = 1'b0;

        case (state_q)
            ST_INIT: begin
                ifid_flush_o = 1'b1;
                idex_flush_o = 1'b1;
                state_d      = ST_RUN;
            end
            ST_RUN: begin
                if (dmem_req_i && !dmem_ack_i) begin
                    mem_hold_o = 1'b1;
                    state_d    = ST_MEM_WAIT;
                    to_d       = TO_W'(1);
                end else begin
                    pc_we_o       = !lu;
                    ifid_we_o     = !lu;
                    idex_flush_o  = lu;
                    ifid_flush_o  = redirect;
                    redirect_fire = redirect;
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ack_i) begin
                    pc_we_o       = !lu;
                    ifid_we_o     = !lu;
                    idex_flush_o  = lu;
                    ifid_flush_o  = redirect;
                    redirect_fire = redirect;
                    state_d       = ST_RUN;
                    to_d          = '0;
                end else if (to_q == TO_LIMIT) begin
                    mem_abort_o = 1'b1;
                    err_set     = 1'b1;
                    state_d     = ST_RUN;
                    to_d        = '0;
                end else begin
                    mem_hold_o = 1'b1;
                    to_d       = to_q + TO_W'(1);
                end
            end
            default: begin
                state_d = ST_INIT;
                to_d    = '0;
            end
        endcase

        if (rst_i) begin
            pc_we_o       = 1'b0;
            ifid_we_o     = 1'b0;
            ifid_flush_o  = 1'b1;
            idex_flush_o  = 1'b1;
            mem_hold_o    = 1'b0;
            mem_abort_o   = 1'b0;
            redirect_fire = 1'b0;
            err_set       = 1'b0;
        end
    end

    // State, timeout counter and sticky error register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_INIT;
            to_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            to_q    <= to_d;
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_o     = err_q;
    assign stall_inc = (state_q != ST_INIT) && !pc_we_o;

    pipe_hazard_ctrl_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (cnt_clr_i),
        .inc_i (stall_inc),
        .cnt_o (stall_cnt_o)
    );

    pipe_hazard_ctrl_sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (cnt_clr_i),
        .inc_i (redirect_fire),
        .cnt_o (flush_cnt_o)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: table of RUN-state vectors plus hand-written multi-cycle sequences.
// Three instances share stimulus: default, short timeout, and narrow counters.
// Checks are made mid-cycle, away from the rising edge.
module tb_pipe_hazard_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [4:0] ifid_rs_i, ifid_rt_i, idex_rt_i;
    logic       ifid_uses_rt_i, idex_memread_i, branch_taken_i, jump_i;
    logic       dmem_req_i, dmem_ack_i, cnt_clr_i;

    logic        pc_we, ifid_we, ifid_flush, idex_flush, mem_hold, mem_abort, err;
    logic [15:0] stall_cnt, flush_cnt;
    logic        t_pc_we, t_ifid_we, t_ifid_flush, t_idex_flush, t_mem_hold, t_mem_abort, t_err;
    logic [15:0] t_stall_cnt, t_flush_cnt;
    logic        s_pc_we, s_ifid_we, s_ifid_flush, s_idex_flush, s_mem_hold, s_mem_abort, s_err;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    pipe_hazard_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i), .ifid_rs_i(ifid_rs_i), .ifid_rt_i(ifid_rt_i),
        .ifid_uses_rt_i(ifid_uses_rt_i), .idex_memread_i(idex_memread_i), .idex_rt_i(idex_rt_i),
        .branch_taken_i(branch_taken_i), .jump_i(jump_i), .dmem_req_i(dmem_req_i),
        .dmem_ack_i(dmem_ack_i), .cnt_clr_i(cnt_clr_i), .pc_we_o(pc_we), .ifid_we_o(ifid_we),
        .ifid_flush_o(ifid_flush), .idex_flush_o(idex_flush), .mem_hold_o(mem_hold),
        .mem_abort_o(mem_abort), .err_o(err), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    pipe_hazard_ctrl #(.MEM_TIMEOUT(3)) dut_t (
        .clk_i(clk_i), .rst_i(rst_i), .ifid_rs_i(ifid_rs_i), .ifid_rt_i(ifid_rt_i),
        .ifid_uses_rt_i(ifid_uses_rt_i), .idex_memread_i(idex_memread_i), .idex_rt_i(idex_rt_i),
        .branch_taken_i(branch_taken_i), .jump_i(jump_i), .dmem_req_i(dmem_req_i),
        .dmem_ack_i(dmem_ack_i), .cnt_clr_i(cnt_clr_i), .pc_we_o(t_pc_we), .ifid_we_o(t_ifid_we),
        .ifid_flush_o(t_ifid_flush), .idex_flush_o(t_idex_flush), .mem_hold_o(t_mem_hold),
        .mem_abort_o(t_mem_abort), .err_o(t_err), .stall_cnt_o(t_stall_cnt), .flush_cnt_o(t_flush_cnt)
    );

    pipe_hazard_ctrl #(.CNT_W(4)) dut_s (
        .clk_i(clk_i), .rst_i(rst_i), .ifid_rs_i(ifid_rs_i), .ifid_rt_i(ifid_rt_i),
        .ifid_uses_rt_i(ifid_uses_rt_i), .idex_memread_i(idex_memread_i), .idex_rt_i(idex_rt_i),
        .branch_taken_i(branch_taken_i), .jump_i(jump_i), .dmem_req_i(dmem_req_i),
        .dmem_ack_i(dmem_ack_i), .cnt_clr_i(cnt_clr_i), .pc_we_o(s_pc_we), .ifid_we_o(s_ifid_we),
        .ifid_flush_o(s_ifid_flush), .idex_flush_o(s_idex_flush), .mem_hold_o(s_mem_hold),
        .mem_abort_o(s_mem_abort), .err_o(s_err), .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt)
    );

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       memread;
        logic [4:0] ex_rt;
        logic       br;
        logic       jmp;
        logic       e_pc_we;
        logic       e_ifid_we;
        logic       e_ifid_flush;
        logic       e_idex_flush;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        ifid_rs_i = 0; ifid_rt_i = 0; ifid_uses_rt_i = 0;
        idex_memread_i = 0; idex_rt_i = 0;
        branch_taken_i = 0; jump_i = 0;
        dmem_req_i = 0; dmem_ack_i = 0; cnt_clr_i = 0;
    endtask

    initial begin
        int exp_stall;
        int exp_flush;

        //           rs  rt  use mr  ert br jmp  pc  ifw iff idf
        vecs[0] = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 0,  1,  1,  0,  0};
        vecs[1] = '{5'd5, 5'd0, 0, 1, 5'd5, 0, 0,  0,  0,  0,  1};
        vecs[2] = '{5'd0, 5'd0, 1, 1, 5'd0, 0, 0,  1,  1,  0,  0};
        vecs[3] = '{5'd3, 5'd7, 0, 1, 5'd7, 0, 0,  1,  1,  0,  0};
        vecs[4] = '{5'd3, 5'd7, 1, 1, 5'd7, 0, 0,  0,  0,  0,  1};
        vecs[5] = '{5'd1, 5'd2, 1, 0, 5'd0, 1, 0,  1,  1,  1,  0};
        vecs[6] = '{5'd1, 5'd2, 1, 1, 5'd9, 0, 1,  1,  1,  1,  0};
        vecs[7] = '{5'd5, 5'd0, 0, 1, 5'd5, 1, 0,  0,  0,  0,  1};
        vecs[8] = '{5'd5, 5'd5, 1, 0, 5'd5, 0, 0,  1,  1,  0,  0};

        clear_inputs();
        rst_i = 1'b1;
        tick();
        tick();
        #3;
        check("rst_pc_we", pc_we, 0);
        check("rst_ifid_we", ifid_we, 0);
        check("rst_ifid_flush", ifid_flush, 1);
        check("rst_idex_flush", idex_flush, 1);
        check("rst_mem_hold", mem_hold, 0);

        // Release reset between edges: the next cycle is INIT.
        rst_i = 1'b0;
        #1;
        check("init_pc_we", pc_we, 0);
        check("init_ifid_flush", ifid_flush, 1);
        check("init_idex_flush", idex_flush, 1);
        check("init_stall_cnt", stall_cnt, 0);
        check("init_flush_cnt", flush_cnt, 0);
        tick();
        #3;
        check("run_pc_we", pc_we, 1);
        check("run_ifid_flush", ifid_flush, 0);
        check("run_idex_flush", idex_flush, 0);
        tick();
        check("run_stall_cnt", stall_cnt, 0);

        // RUN-state combinational decode, with counter expectations accumulated from the table.
        exp_stall = 0;
        exp_flush = 0;
        for (int i = 0; i < 9; i++) begin
            ifid_rs_i      = vecs[i].rs;
            ifid_rt_i      = vecs[i].rt;
            ifid_uses_rt_i = vecs[i].uses_rt;
            idex_memread_i = vecs[i].memread;
            idex_rt_i      = vecs[i].ex_rt;
            branch_taken_i = vecs[i].br;
            jump_i         = vecs[i].jmp;
            #3;
            check($sformatf("v%0d_pc_we", i), pc_we, vecs[i].e_pc_we);
            check($sformatf("v%0d_ifid_we", i), ifid_we, vecs[i].e_ifid_we);
            check($sformatf("v%0d_ifid_flush", i), ifid_flush, vecs[i].e_ifid_flush);
            check($sformatf("v%0d_idex_flush", i), idex_flush, vecs[i].e_idex_flush);
            check($sformatf("v%0d_mem_hold", i), mem_hold, 0);
            if (!vecs[i].e_pc_we) exp_stall++;
            if (vecs[i].e_ifid_flush) exp_flush++;
            tick();
            check($sformatf("v%0d_stall_cnt", i), stall_cnt, exp_stall);
            check($sformatf("v%0d_flush_cnt", i), flush_cnt, exp_flush);
        end

        clear_inputs();
        cnt_clr_i = 1'b1;
        tick();
        cnt_clr_i = 1'b0;
        check("clr_stall_cnt", stall_cnt, 0);
        check("clr_flush_cnt", flush_cnt, 0);

        // Timeout on the short-timeout instance: three frozen cycles, abort on the fourth.
        dmem_req_i = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            #3;
            check($sformatf("to_c%0d_hold", k), t_mem_hold, 1);
            check($sformatf("to_c%0d_abort", k), t_mem_abort, 0);
            check($sformatf("to_c%0d_pc_we", k), t_pc_we, 0);
            tick();
        end
        #3;
        check("to_c4_abort", t_mem_abort, 1);
        check("to_c4_hold", t_mem_hold, 0);
        check("to_c4_err_before_edge", t_err, 0);
        tick();
        dmem_req_i = 1'b0;
        dmem_ack_i = 1'b1;
        #3;
        check("to_err_set", t_err, 1);
        check("to_abort_one_cycle", t_mem_abort, 0);
        check("to_back_in_run", t_pc_we, 1);
        check("to_stall_cnt", t_stall_cnt, 4);
        check("dflt_ack_release", mem_hold, 0);
        tick();
        dmem_ack_i = 1'b0;
        tick();
        check("to_err_sticky", t_err, 1);
        check("dflt_no_err", err, 0);

        cnt_clr_i = 1'b1;
        tick();
        cnt_clr_i = 1'b0;

        // Memory wait released by an ack four cycles after the request.
        dmem_req_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #3;
            check($sformatf("ack_c%0d_hold", k), mem_hold, 1);
            check($sformatf("ack_c%0d_pc_we", k), pc_we, 0);
            check($sformatf("ack_c%0d_ifid_we", k), ifid_we, 0);
            tick();
        end
        dmem_ack_i = 1'b1;
        #3;
        check("ack_hold_release", mem_hold, 0);
        check("ack_pc_we", pc_we, 1);
        check("ack_ifid_we", ifid_we, 1);
        check("ack_no_abort", mem_abort, 0);
        tick();
        dmem_req_i = 1'b0;
        dmem_ack_i = 1'b0;
        check("ack_stall_cnt", stall_cnt, 4);
        #3;
        check("ack_back_in_run", pc_we, 1);
        tick();

        // Reset in the middle of a memory wait drops the access without an abort.
        dmem_req_i = 1'b1;
        tick();
        tick();
        #2;
        rst_i = 1'b1;
        #1;
        check("rstw_abort", mem_abort, 0);
        check("rstw_hold", mem_hold, 0);
        check("rstw_pc_we", pc_we, 0);
        check("rstw_ifid_flush", ifid_flush, 1);
        dmem_req_i = 1'b0;
        tick();
        rst_i = 1'b0;
        #3;
        check("rstw_init_pc_we", pc_we, 0);
        check("rstw_init_idex_flush", idex_flush, 1);
        check("rstw_stall_cnt", stall_cnt, 0);
        check("rstw_err_cleared", t_err, 0);
        tick();
        #3;
        check("rstw_run_pc_we", pc_we, 1);
        check("rstw_run_hold", mem_hold, 0);
        tick();

        // Held load-use hazard saturates the narrow counter; clear beats increment.
        idex_memread_i = 1'b1;
        idex_rt_i      = 5'd5;
        ifid_rs_i      = 5'd5;
        repeat (20) tick();
        check("sat_narrow_stall", s_stall_cnt, 15);
        check("sat_wide_stall", stall_cnt, 20);
        check("sat_flush_cnt", flush_cnt, 0);
        repeat (3) tick();
        check("sat_hold", s_stall_cnt, 15);
        cnt_clr_i = 1'b1;
        tick();
        check("sat_clr_narrow", s_stall_cnt, 0);
        check("sat_clr_wide", stall_cnt, 0);
        clear_inputs();
        tick();
        check("post_clr_no_stall", stall_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
